// File: rtl/uart_cmd_tx.sv
// UART transmitter for 8-bit motor command bytes: start, 8 data bits LSB-first,
// optional even/odd parity, 1 or 2 stop bits. Bytes are accepted over valid/ready.
`timescale 1ns/1ps

module uart_cmd_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
    localparam bit PARAMS_OK = (CLKS_PER_BIT >= 2) &&
                               (STOP_BITS == 1 || STOP_BITS == 2) &&
                               (PARITY <= 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             tx_d, busy_d, done_d;
    logic             baud_end;
    logic             accept;

    assign tx_ready = (state_q == S_IDLE) && !rst;
    assign accept   = tx_valid && tx_ready;
    assign baud_end = (cnt_q == CNT_LAST);

    // State, datapath and registered line outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx      <= tx_d;
            tx_busy <= busy_d;
            tx_done <= done_d;
        end
    end

    // Next-state logic; line level is derived from the state being entered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;

        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = baud_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (accept) begin
                    shift_d = tx_data;
                    par_d   = (PARITY == 2) ? ~^tx_data : ^tx_data;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    a_params_legal: assert property (@(posedge clk) PARAMS_OK)
        else $error("uart_cmd_tx: unsupported parameter combination");

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Directed bench for uart_cmd_tx: four instances cover no/even/odd parity and two stop bits.
`timescale 1ns/1ps

module tb_uart_cmd_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic [3:0] valid = 4'h0;
    logic [3:0] ready, tx, busy, done;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int s1 = 0;
    int t = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_cmd_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(0)) u_p0 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx(tx[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_cmd_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(1)) u_even (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx(tx[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_cmd_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(2)) u_odd (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx(tx[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    uart_cmd_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY(0)) u_stop2 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[3]),
        .tx_ready(ready[3]), .tx(tx[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a byte to instance i and release valid just after the accepting edge
    task automatic send(input int i, input logic [7:0] b);
        int w;
        @(negedge clk);
        tx_data  = b;
        valid[i] = 1'b1;
        w = 0;
        while (!ready[i] && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", 32'(ready[i]), 32'd1);
        @(posedge clk);
        #1 valid[i] = 1'b0;
    endtask

    // Check every cycle of a frame from the cycle after acceptance, then the tx_done cycle
    task automatic frame_check(input int i, input logic [7:0] b, input int parbit,
                               input int stops, input bit scramble);
        int lv[$];
        lv.push_back(0);
        for (int k = 0; k < 8; k++) lv.push_back(int'(b[k]));
        if (parbit >= 0) lv.push_back(parbit);
        for (int s = 0; s < stops; s++) lv.push_back(1);
        for (int l = 0; l < lv.size(); l++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (l == 0 && c == 0) start_cyc = cyc;
                if (scramble && l == 1 && c == 0) tx_data = 8'hFF;
                chk($sformatf("u%0d tx lvl%0d c%0d", i, l, c), 32'(tx[i]), 32'(lv[l]));
                if (c == 0) begin
                    chk($sformatf("u%0d busy lvl%0d", i, l), 32'(busy[i]), 32'd1);
                    chk($sformatf("u%0d done lvl%0d", i, l), 32'(done[i]), 32'd0);
                end
            end
        end
        @(negedge clk);
        chk($sformatf("u%0d done_pulse", i), 32'(done[i]), 32'd1);
        chk($sformatf("u%0d busy_end", i), 32'(busy[i]), 32'd0);
        chk($sformatf("u%0d ready_end", i), 32'(ready[i]), 32'd1);
    endtask

    initial begin
        // Reset behaviour
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            chk("rst tx", 32'(tx), 32'hF);
            chk("rst busy", 32'(busy), 32'h0);
            chk("rst ready", 32'(ready), 32'h0);
            chk("rst done", 32'(done), 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst ready", 32'(ready), 32'hF);

        // Basic frame, 0x35
        send(0, 8'h35);
        frame_check(0, 8'h35, -1, 1, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done[0]), 32'd0);

        // Back-to-back with valid held: 0x01 then 0x80
        @(negedge clk);
        tx_data  = 8'h01;
        valid[0] = 1'b1;
        t = 0;
        while (!ready[0] && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("b2b ready", 32'(ready[0]), 32'd1);
        @(posedge clk);
        #1 tx_data = 8'h80;
        frame_check(0, 8'h01, -1, 1, 1'b0);
        s1 = start_cyc;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        frame_check(0, 8'h80, -1, 1, 1'b0);
        chk("b2b period", 32'(start_cyc - s1), 32'd41);

        // Data captured at acceptance; bus changes mid-frame are ignored
        send(0, 8'hA5);
        frame_check(0, 8'hA5, -1, 1, 1'b1);

        // Parity and two stop bits
        send(1, 8'h07);
        frame_check(1, 8'h07, 1, 1, 1'b0);
        send(2, 8'h07);
        frame_check(2, 8'h07, 0, 1, 1'b0);
        send(3, 8'h35);
        frame_check(3, 8'h35, -1, 2, 1'b0);

        // Reset during data bit 3 of 0x00
        send(0, 8'h00);
        repeat (18) @(negedge clk);
        chk("pre_abort tx", 32'(tx[0]), 32'd0);
        chk("pre_abort busy", 32'(busy[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort tx async", 32'(tx[0]), 32'd1);
        chk("abort busy", 32'(busy[0]), 32'd0);
        chk("abort ready", 32'(ready[0]), 32'd0);
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk("abort done", 32'(done[0]), 32'd0);
            chk("abort tx hold", 32'(tx[0]), 32'd1);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("abort post done", 32'(done[0]), 32'd0);
        chk("abort post ready", 32'(ready[0]), 32'd1);
        send(0, 8'h3C);
        frame_check(0, 8'h3C, -1, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
